filter2d_ctrl: RTL and testbench

Job controller for the 3x3 2D filter engine. It holds a shadow copy of the nine signed coefficients written by the host. On a go command it programs the engine's coefficient bank serially and pulses the engine's start. It then collects the engine's output strobes, writes each output pixel to the result memory in raster order, and signals completion.

---
 rtl/filter2d_ctrl_if.sv | 32 +++
 rtl/filter2d_ctrl.sv | 146 ++++++++++++++
 tb/tb_filter2d_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/filter2d_ctrl_if.sv
// Bundle of host, engine and result-memory signals for the 2D filter job controller.
// The slave side is the controller itself; the master side drives it.
interface filter2d_ctrl_if;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [7:0]  cfg_wdata;
   logic        go;
   logic        busy;
   logic        done;
   logic        err;
   logic        h_write;
   logic [3:0]  h_idx;
   logic [7:0]  h_data;
   logic        f_start;
   logic        f_strb;
   logic [7:0]  f_data;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, go, f_strb, f_data,
      output busy, done, err, h_write, h_idx, h_data, f_start,
      output wr_en, wr_addr, wr_data
   );

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, go, f_strb, f_data,
      input  busy, done, err, h_write, h_idx, h_data, f_start,
      input  wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/filter2d_ctrl.sv
// Job controller for the 3x3 filter engine: shadow coefficients, serial
// coefficient load, engine start, raster-order result writes and completion.
module filter2d_ctrl #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int NTAP  = 9
) (
   input logic           clk,
   input logic           rstn,
   filter2d_ctrl_if.slave bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] RUN   = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [3:0]  LAST_TAP = 4'(NTAP - 1);
   localparam logic [16:0] LAST_PIX = 17'(IMG_W * IMG_H - 1);

   // Reset kernel of the engine; the shadow starts out matching it.
   function automatic logic [7:0] def_coef(input int i);
      if (i == 4)
         return 8'h20;
      else if ((i % 2) == 1)
         return 8'h10;
      else
         return 8'h08;
   endfunction

   logic [2:0]  state_q, state_d;
   logic [3:0]  h_idx_q, h_idx_d;
   logic [7:0]  h_data_q, h_data_d;
   logic        h_write_q, h_write_d;
   logic        f_start_q, f_start_d;
   logic [16:0] cnt_q, cnt_d;
   logic        wr_en_q, wr_en_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        err_q, err_d;
   logic [7:0]  shadow_q [NTAP];
   logic [7:0]  shadow_d [NTAP];

   // Next-state logic: shadow writes, FSM sequencing and registered outputs.
   always_comb begin
      state_d   = state_q;
      h_idx_d   = h_idx_q;
      h_data_d  = h_data_q;
      h_write_d = h_write_q;
      f_start_d = 1'b0;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      shadow_d  = shadow_q;
      err_d     = (bus.go || bus.cfg_we) && (state_q != IDLE);

      // Shadow write lands before the go in the same cycle is acted on.
      if (bus.cfg_we && state_q == IDLE && bus.cfg_addr <= LAST_TAP)
         shadow_d[bus.cfg_addr] = bus.cfg_wdata;

      unique case (state_q)
         IDLE: begin
            if (bus.go) begin
               state_d   = LOAD;
               h_write_d = 1'b1;
               h_idx_d   = 4'd0;
               h_data_d  = shadow_d[0];
            end
         end
         LOAD: begin
            if (h_idx_q == LAST_TAP) begin
               h_write_d = 1'b0;
               f_start_d = 1'b1;
               state_d   = START;
            end else begin
               h_idx_d  = h_idx_q + 4'd1;
               h_data_d = shadow_q[h_idx_q + 4'd1];
            end
         end
         START: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (bus.f_strb) begin
               wr_en_d   = 1'b1;
               wr_data_d = bus.f_data;
               wr_addr_d = cnt_q[15:0];
               cnt_d     = cnt_q + 17'd1;
               if (cnt_q == LAST_PIX)
                  state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset restores the shadow to the engine kernel.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         h_idx_q   <= '0;
         h_data_q  <= '0;
         h_write_q <= 1'b0;
         f_start_q <= 1'b0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < NTAP; i++)
            shadow_q[i] <= def_coef(i);
      end else begin
         state_q   <= state_d;
         h_idx_q   <= h_idx_d;
         h_data_q  <= h_data_d;
         h_write_q <= h_write_d;
         f_start_q <= f_start_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
         shadow_q  <= shadow_d;
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.err     = err_q;
   assign bus.h_write = h_write_q;
   assign bus.h_idx   = h_idx_q;
   assign bus.h_data  = h_data_q;
   assign bus.f_start = f_start_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_filter2d_ctrl.sv
// Directed bench for filter2d_ctrl: coefficient load, shadow writes,
// full-frame result writes, rejected requests, stray strobes and mid-job reset.
module tb_filter2d_ctrl;

   localparam int NPIX = 65536;

   logic clk;
   logic rstn;
   int   vecs;
   int   errs;
   logic [7:0] exp_k [9];

   filter2d_ctrl_if b();

   filter2d_ctrl dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_defaults();
      exp_k = '{8'h08, 8'h10, 8'h08, 8'h10, 8'h20,
                8'h10, 8'h08, 8'h10, 8'h08};
   endtask

   task automatic test_reset(input string tag);
      logic [50:0] got;
      got = {b.busy, b.done, b.err, b.h_write, b.f_start, b.wr_en,
             b.h_idx, b.h_data, b.wr_addr, b.wr_data};
      vecs++;
      if (got !== 51'd0) begin
         errs++;
         $display("FAIL %s: outputs=%h required 0", tag, got);
      end
   endtask

   task automatic test_load(input string tag, input logic we,
                            input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      b.go = 1'b1;
      b.cfg_we = we;
      b.cfg_addr = a;
      b.cfg_wdata = d;
      @(negedge clk);
      b.go = 1'b0;
      b.cfg_we = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         vecs++;
         if ({b.h_write, b.h_idx, b.h_data, b.f_start, b.wr_en} !==
             {1'b1, 4'(i), exp_k[i], 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL %s_tap%0d: wr=%b idx=%0d data=%h st=%b we=%b required 1 %0d %h 0 0",
                     tag, i, b.h_write, b.h_idx, b.h_data, b.f_start,
                     b.wr_en, i, exp_k[i]);
         end
         b.f_strb = 1'b1;
         b.f_data = 8'hAA;
      end
      @(negedge clk);
      b.f_strb = 1'b0;
      vecs++;
      if ({b.f_start, b.h_write, b.wr_en, b.busy} !== 4'b1001) begin
         errs++;
         $display("FAIL %s_start: st/hw/we/busy=%b required 1001",
                  tag, {b.f_start, b.h_write, b.wr_en, b.busy});
      end
      @(negedge clk);
      vecs++;
      if ({b.f_start, b.wr_en, b.busy} !== 3'b001) begin
         errs++;
         $display("FAIL %s_run: st/we/busy=%b required 001",
                  tag, {b.f_start, b.wr_en, b.busy});
      end
   endtask

   task automatic test_partial(input string tag, input int n);
      for (int i = 0; i <= n; i++) begin
         if (i > 0) begin
            vecs++;
            if ({b.wr_en, b.wr_addr, b.wr_data, b.done} !==
                {1'b1, 16'(i - 1), 8'(i - 1) ^ 8'h3C, 1'b0}) begin
               errs++;
               $display("FAIL %s_wr%0d: en=%b addr=%0d data=%h done=%b required 1 %0d %h 0",
                        tag, i - 1, b.wr_en, b.wr_addr, b.wr_data, b.done,
                        i - 1, 8'(i - 1) ^ 8'h3C);
            end
         end
         b.f_strb = (i < n);
         b.f_data = 8'(i) ^ 8'h3C;
         if (i < n) @(negedge clk);
      end
   endtask

   task automatic test_full_job();
      int nerr;
      nerr = 0;
      for (int i = 0; i <= NPIX; i++) begin
         if (b.err === 1'b1) nerr++;
         if (i > 0) begin
            vecs++;
            if ({b.wr_en, b.wr_addr, b.wr_data, b.done, b.busy} !==
                {1'b1, 16'(i - 1), 8'(i - 1), i == NPIX, 1'b1}) begin
               errs++;
               $display("FAIL full_wr%0d: en=%b addr=%0d data=%h done=%b busy=%b required 1 %0d %h %b 1",
                        i - 1, b.wr_en, b.wr_addr, b.wr_data, b.done,
                        b.busy, i - 1, 8'(i - 1), i == NPIX);
            end
         end
         b.go = (i == 100);
         b.cfg_we = (i == 200);
         b.cfg_addr = 4'd4;
         b.cfg_wdata = 8'h55;
         b.f_strb = (i < NPIX);
         b.f_data = 8'(i);
         if (i < NPIX) @(negedge clk);
      end
      b.go = 1'b0;
      b.cfg_we = 1'b0;
      vecs++;
      if (nerr != 2) begin
         errs++;
         $display("FAIL full_err: err pulses=%0d required 2", nerr);
      end
      @(negedge clk);
      vecs++;
      if ({b.busy, b.done, b.wr_en, b.err} !== 4'b0000) begin
         errs++;
         $display("FAIL full_idle: busy/done/we/err=%b required 0000",
                  {b.busy, b.done, b.wr_en, b.err});
      end
   endtask

   task automatic test_shadow_write();
      @(negedge clk);
      b.cfg_we = 1'b1;
      b.cfg_addr = 4'd4;
      b.cfg_wdata = 8'h7F;
      @(negedge clk);
      b.cfg_addr = 4'd9;
      b.cfg_wdata = 8'h33;
      @(negedge clk);
      b.cfg_we = 1'b0;
      @(negedge clk);
      vecs++;
      if ({b.err, b.busy} !== 2'b00) begin
         errs++;
         $display("FAIL bad_addr: err/busy=%b required 00", {b.err, b.busy});
      end
      set_defaults();
      exp_k[4] = 8'h7F;
      exp_k[0] = 8'hF0;
      test_load("shadow", 1'b1, 4'd0, 8'hF0);
   endtask

   task automatic test_stray_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vecs++;
         if ({b.wr_en, b.busy} !== 2'b00) begin
            errs++;
            $display("FAIL stray_idle%0d: we/busy=%b required 00",
                     i, {b.wr_en, b.busy});
         end
         b.f_strb = 1'b1;
         b.f_data = 8'h77;
      end
      @(negedge clk);
      b.f_strb = 1'b0;
      vecs++;
      if (b.wr_en !== 1'b0) begin
         errs++;
         $display("FAIL stray_idle_last: we=%b required 0", b.wr_en);
      end
   endtask

   task automatic test_mid_reset();
      b.f_strb = 1'b0;
      rstn = 1'b0;
      #1;
      test_reset("mid_reset");
      @(negedge clk);
      @(negedge clk);
      test_reset("mid_reset_hold");
      rstn = 1'b1;
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      rstn = 1'b0;
      b.cfg_we = 1'b0;
      b.cfg_addr = 4'd0;
      b.cfg_wdata = 8'd0;
      b.go = 1'b0;
      b.f_strb = 1'b0;
      b.f_data = 8'd0;
      @(negedge clk);
      @(negedge clk);
      test_reset("reset");
      rstn = 1'b1;

      set_defaults();
      test_load("default", 1'b0, 4'd0, 8'd0);
      test_mid_reset();

      test_shadow_write();
      test_full_job();

      set_defaults();
      exp_k[4] = 8'h7F;
      exp_k[0] = 8'hF0;
      test_load("second", 1'b0, 4'd0, 8'd0);
      test_partial("second", 1000);
      test_mid_reset();

      test_stray_idle();
      set_defaults();
      test_load("after_reset", 1'b0, 4'd0, 8'd0);
      test_partial("after_reset", 3);
      test_mid_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
